// File: rtl/div_rr_sched_if.sv
// rtl/div_rr_sched_if.sv - request/response bundle for the shared round-robin divider
interface div_rr_sched_if #(
    parameter int WIDTH = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_dividend;
    logic [WIDTH-1:0] req0_divisor;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_dividend;
    logic [WIDTH-1:0] req1_divisor;
    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic [WIDTH-1:0] resp_quotient;
    logic [WIDTH-1:0] resp_remainder;
    logic             resp_divzero;
    logic             busy;

    modport master (
        output req0_valid, req0_dividend, req0_divisor,
        output req1_valid, req1_dividend, req1_divisor,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_quotient, resp_remainder, resp_divzero, busy
    );

    modport slave (
        input  req0_valid, req0_dividend, req0_divisor,
        input  req1_valid, req1_dividend, req1_divisor,
        input  resp_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_quotient, resp_remainder, resp_divzero, busy
    );
endinterface

// File: rtl/div_rr_sched.sv
// rtl/div_rr_sched.sv - two-client round-robin scheduler over a restoring divider
// Optional macro DIV_ZERO_SHORTCUT_EN: a zero divisor skips the iteration phase.
module div_rr_sched #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input logic           clk,
    input logic           rst,
    div_rr_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q, state_d;
    logic               last_q, last_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               id_q, id_d;
    logic               dz_q, dz_d;
    logic               gnt0, gnt1;
    logic [WIDTH:0]     acc_sh;
    logic [WIDTH-1:0]   sel_dividend, sel_divisor;

    // last_q holds the id served most recently; reset value 1 gives requester 0 priority
    always_comb begin
        gnt0         = bus.req0_valid && (!bus.req1_valid || last_q);
        gnt1         = bus.req1_valid && (!bus.req0_valid || !last_q);
        sel_dividend = gnt1 ? bus.req1_dividend : bus.req0_dividend;
        sel_divisor  = gnt1 ? bus.req1_divisor  : bus.req0_divisor;
        acc_sh       = {acc_q[WIDTH-1:0], shreg_q[WIDTH-1]};
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        acc_d   = acc_q;
        shreg_d = shreg_q;
        dvsr_d  = dvsr_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    id_d    = gnt1;
                    last_d  = gnt1;
                    dvsr_d  = sel_divisor;
                    shreg_d = sel_dividend;
                    acc_d   = '0;
                    cnt_d   = '0;
                    dz_d    = (sel_divisor == '0);
                    state_d = CALC;
`ifdef DIV_ZERO_SHORTCUT_EN
                    if (sel_divisor == '0) begin
                        shreg_d = '1;
                        acc_d   = {1'b0, sel_dividend};
                        state_d = DONE;
                    end
`endif
                end
            end
            CALC: begin
                if (acc_sh >= {1'b0, dvsr_q}) begin
                    acc_d   = acc_sh - {1'b0, dvsr_q};
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d   = acc_sh;
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            acc_q   <= '0;
            shreg_q <= '0;
            dvsr_q  <= '0;
            cnt_q   <= '0;
            id_q    <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            acc_q   <= acc_d;
            shreg_q <= shreg_d;
            dvsr_q  <= dvsr_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.req0_ready     = (state_q == IDLE) && gnt0;
    assign bus.req1_ready     = (state_q == IDLE) && gnt1;
    assign bus.resp_valid     = (state_q == DONE);
    assign bus.busy           = (state_q != IDLE);
    assign bus.resp_id        = id_q;
    assign bus.resp_quotient  = shreg_q;
    assign bus.resp_remainder = acc_q[WIDTH-1:0];
    assign bus.resp_divzero   = dz_q;
endmodule

// File: tb/tb_div_rr_sched.sv
// tb/tb_div_rr_sched.sv - scoreboard bench for div_rr_sched against an arithmetic model
module tb_div_rr_sched;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    typedef struct {
        logic             id;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dz;
        int               lat;
        int               acc_cyc;
    } exp_t;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } op_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    logic last_id;
    exp_t sb[$];
    op_t  q0[$];
    op_t  q1[$];

    div_rr_sched_if #(.WIDTH(WIDTH)) bus ();

    div_rr_sched #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: condition not reached within cycle budget (cycle %0d)", name, cyc);
    endtask

    function automatic exp_t model(input logic id, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b, input int c);
        exp_t e;
        e.id = id;
        e.acc_cyc = c;
        e.lat = WIDTH;
        if (b == 0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
`ifdef DIV_ZERO_SHORTCUT_EN
            e.lat = 1;
`endif
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.a = WIDTH'($urandom_range(255));
        case ($urandom_range(7))
            0:       o.b = '0;
            1:       o.b = WIDTH'(128 + $urandom_range(127));
            2:       o.b = WIDTH'(1);
            default: o.b = WIDTH'($urandom_range(255));
        endcase
        return o;
    endfunction

    // Idle exactly when no operation is outstanding in the scoreboard
    task automatic accept_step(output int who);
        bit v0, v1, idle;
        int g;
        v0 = bus.req0_valid;
        v1 = bus.req1_valid;
        idle = (sb.size() == 0);
        g = -1;
        if (idle) begin
            if (v0 && v1) g = last_id ? 0 : 1;
            else if (v0)  g = 0;
            else if (v1)  g = 1;
        end
        chk("busy", longint'(bus.busy), longint'(!idle));
        chk("ready_pair", longint'({bus.req1_ready, bus.req0_ready}),
            (g == 0) ? 1 : (g == 1) ? 2 : 0);
        if (g == 0) sb.push_back(model(1'b0, bus.req0_dividend, bus.req0_divisor, cyc + 1));
        if (g == 1) sb.push_back(model(1'b1, bus.req1_dividend, bus.req1_divisor, cyc + 1));
        if (g >= 0) last_id = g[0];
        who = g;
    endtask

    task automatic drive(input bit rand_vld, input bit rand_rdy);
        if (q0.size() > 0) begin
            bus.req0_valid    = !rand_vld || ($urandom_range(3) != 0);
            bus.req0_dividend = q0[0].a;
            bus.req0_divisor  = q0[0].b;
        end else begin
            bus.req0_valid    = 1'b0;
            bus.req0_dividend = WIDTH'($urandom);
            bus.req0_divisor  = WIDTH'($urandom);
        end
        if (q1.size() > 0) begin
            bus.req1_valid    = !rand_vld || ($urandom_range(3) != 0);
            bus.req1_dividend = q1[0].a;
            bus.req1_divisor  = q1[0].b;
        end else begin
            bus.req1_valid    = 1'b0;
            bus.req1_dividend = WIDTH'($urandom);
            bus.req1_divisor  = WIDTH'($urandom);
        end
        bus.resp_ready = !rand_rdy || ($urandom_range(3) != 0);
    endtask

    task automatic run_ops(input bit rand_vld, input bit rand_rdy, input string name);
        int budget;
        int who;
        budget = 4000;
        while (budget > 0 && (q0.size() > 0 || q1.size() > 0 || sb.size() > 0)) begin
            @(posedge clk);
            #1;
            drive(rand_vld, rand_rdy);
            @(negedge clk);
            accept_step(who);
            if (who == 0 && q0.size() > 0) void'(q0.pop_front());
            if (who == 1 && q1.size() > 0) void'(q1.pop_front());
            budget--;
        end
        if (budget == 0) fail_now(name);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.resp_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        sb.delete();
        last_id = 1'b1;
        @(negedge clk);
        chk("rst_resp_valid", longint'(bus.resp_valid), 0);
        chk("rst_busy", longint'(bus.busy), 0);
        chk("rst_ready_pair", longint'({bus.req1_ready, bus.req0_ready}), 0);
        chk("rst_resp_id", longint'(bus.resp_id), 0);
        chk("rst_quotient", longint'(bus.resp_quotient), 0);
        chk("rst_remainder", longint'(bus.resp_remainder), 0);
        chk("rst_divzero", longint'(bus.resp_divzero), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_accept(input string name);
        int who;
        int budget;
        who = -1;
        budget = 50;
        while (who < 0 && budget > 0) begin
            @(negedge clk);
            accept_step(who);
            budget--;
        end
        if (who < 0) fail_now(name);
    endtask

    // Monitor: latency on each rising resp_valid, result fields on each handshake
    initial begin
        bit   prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                prev = 1'b0;
            end else begin
                if (bus.resp_valid && !prev) begin
                    if (sb.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_resp: resp_valid with nothing outstanding (cycle %0d)", cyc);
                    end else begin
                        chk("latency", cyc - sb[0].acc_cyc, sb[0].lat);
                    end
                end
                if (bus.resp_valid && bus.resp_ready && sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("resp_id", longint'(bus.resp_id), longint'(e.id));
                    chk("resp_quotient", longint'(bus.resp_quotient), longint'(e.q));
                    chk("resp_remainder", longint'(bus.resp_remainder), longint'(e.r));
                    chk("resp_divzero", longint'(bus.resp_divzero), longint'(e.dz));
                end
                prev = bus.resp_valid;
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] cq, cr;
        int budget;
        int seen;
        int who;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_dividend = '0;
        bus.req0_divisor  = '0;
        bus.req1_dividend = '0;
        bus.req1_divisor  = '0;
        bus.resp_ready = 1'b1;
        do_reset();

        q0.push_back('{8'd100, 8'd7});
        run_ops(1'b0, 1'b0, "op_100_7");
        q1.push_back('{8'd255, 8'd200});
        q1.push_back('{8'd255, 8'd129});
        run_ops(1'b0, 1'b0, "op_255_wide");

        @(posedge clk);
        #1;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            q0.push_back('{8'd50, 8'd3});
            q1.push_back('{8'd9, 8'd9});
        end
        run_ops(1'b0, 1'b0, "rr_alternate");

        q0.push_back('{8'd37, 8'd0});
        run_ops(1'b0, 1'b0, "divzero");

        // Backpressure: response held while a second request waits
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_dividend = 8'd77;
        bus.req0_divisor  = 8'd5;
        wait_accept("bp_accept");
        @(posedge clk);
        #1;
        bus.req0_dividend = 8'd60;
        bus.req0_divisor  = 8'd4;
        budget = 30;
        do begin
            @(negedge clk);
            accept_step(who);
            budget--;
        end while (!bus.resp_valid && budget > 0);
        if (!bus.resp_valid) fail_now("bp_resp");
        cq = 8'd15;
        cr = 8'd2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            accept_step(who);
            chk("bp_valid_held", longint'(bus.resp_valid), 1);
            chk("bp_quotient_held", longint'(bus.resp_quotient), longint'(cq));
            chk("bp_remainder_held", longint'(bus.resp_remainder), longint'(cr));
        end
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        accept_step(who);
        @(negedge clk);
        accept_step(who);
        chk("accept_after_release", longint'(bus.req0_ready), 1);
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        run_ops(1'b0, 1'b0, "bp_drain");

        // Abort after three iterations
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b1;
        bus.req0_dividend = 8'd123;
        bus.req0_divisor  = 8'd4;
        wait_accept("abort_accept");
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.resp_valid) seen++;
        end
        chk("no_resp_after_abort", seen, 0);
        q0.push_back('{8'd200, 8'd13});
        run_ops(1'b0, 1'b0, "op_200_13");

        for (int i = 0; i < 30; i++) begin
            q0.push_back(rand_op());
            q1.push_back(rand_op());
        end
        run_ops(1'b1, 1'b1, "random");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
